// File: rtl/mac_booth_seq.sv
// mac_booth_seq: sequential radix-4 Booth multiply-accumulate, one Booth step per clock
module mac_booth_seq #(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      x,
    input  logic [15:0]      y,
    input  logic             msub,
    input  logic             clr,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] acc,
    output logic [2:0]       y_trip,
    output logic [2:0]       step
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [15:0]      x_q, y_q;
    logic             msub_q;
    logic [2:0]       step_q, step_d;
    logic [ACC_W-1:0] acc_q, acc_d, pp_w;
    logic [16:0]      y_ext;
    logic [2:0]       trip;
    logic [17:0]      x18, mag, pp;
    logic             accept;
    assign accept = (state_q == IDLE) && start;
    // y[-1] is the appended zero below the LSB
    assign y_ext = {y_q, 1'b0};
    assign trip  = y_ext[{step_q, 1'b0} +: 3];
    assign x18   = {{2{x_q[15]}}, x_q};
    // 011/100 select 2X, 000/111 select zero, the rest select X
    assign mag   = (trip == 3'b011 || trip == 3'b100) ? {x18[16:0], 1'b0} :
                   (trip == 3'b000 || trip == 3'b111) ? 18'd0 : x18;
    // negative triplets negate; subtract mode flips that sign again
    assign pp    = (trip[2] ^ msub_q) ? -mag : mag;
    assign pp_w  = {{(ACC_W-18){pp[17]}}, pp} << {step_q, 1'b0};
    assign acc_d = (accept && clr) ? '0 : (state_q == RUN) ? acc_q + pp_w : acc_q;
    assign step_d = accept ? 3'd0 : (state_q == RUN) ? step_q + 3'd1 : step_q;
    assign acc   = acc_q;
    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    // next state: IDLE waits for start, RUN lasts eight steps, DONE lasts one cycle
    always_comb begin
        state_d = (state_q == IDLE) ? (start ? RUN : IDLE) :
                  (state_q == RUN)  ? ((step_q == 3'd7) ? DONE : RUN) : IDLE;
    end
    // operand latch, step counter and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            y_q    <= '0;
            msub_q <= 1'b0;
            step_q <= '0;
            acc_q  <= '0;
        end else begin
            if (accept) begin
                x_q    <= x;
                y_q    <= y;
                msub_q <= msub;
            end
            step_q <= step_d;
            acc_q  <= acc_d;
        end
    end
    // status outputs; ready is held low while reset is asserted
    always_comb begin
        ready  = rst_n && (state_q == IDLE);
        busy   = (state_q == RUN);
        done   = (state_q == DONE);
        y_trip = busy ? trip : 3'd0;
        step   = busy ? step_q : 3'd0;
    end
endmodule

// File: tb/tb_mac_booth_seq.sv
// tb_mac_booth_seq: directed vector table plus corner sequences for mac_booth_seq
module tb_mac_booth_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] x = '0;
    logic [15:0] y = '0;
    logic        msub = 1'b0;
    logic        clr = 1'b0;
    logic        ready, busy, done;
    logic [39:0] acc;
    logic [2:0]  y_trip, step;
    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        msub;
        logic        clr;
        logic [39:0] exp;
    } vec_t;
    vec_t vt[9];

    mac_booth_seq #(.ACC_W(40)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .msub(msub), .clr(clr),
        .ready(ready), .busy(busy), .done(done), .acc(acc), .y_trip(y_trip), .step(step)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("ready_wait", {63'd0, ready}, 64'd1);
    endtask

    // one full operation: checks latency, busy length, per-step triplet/index and final acc
    task automatic run_op(input logic [15:0] xi, input logic [15:0] yi, input logic mi,
                          input logic ci, input logic [39:0] exp, input string tag);
        int busy_n = 0;
        int done_at = 0;
        logic [16:0] y17;
        logic [2:0]  et;
        wait_ready();
        x = xi; y = yi; msub = mi; clr = ci; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        y17 = {yi, 1'b0};
        for (int n = 1; n <= 14 && done_at == 0; n++) begin
            @(negedge clk);
            if (busy) begin
                et = y17[2*busy_n +: 3];
                chk({tag, "_trip"}, {61'd0, y_trip}, {61'd0, et});
                chk({tag, "_step"}, {61'd0, step}, 64'(busy_n));
                busy_n++;
            end
            if (done) done_at = n;
        end
        chk({tag, "_latency"}, 64'(done_at), 64'd9);
        chk({tag, "_busy_len"}, 64'(busy_n), 64'd8);
        chk({tag, "_acc"}, {24'd0, acc}, {24'd0, exp});
    endtask

    initial begin
        int dcount;
        int found;
        logic [39:0] m;
        longint p;
        logic [15:0] rx, ry;
        logic rm, rc;
        vt[0] = '{16'd3,    16'd5,    1'b0, 1'b1, 40'd15};
        vt[1] = '{16'hFFFE, 16'd7,    1'b1, 1'b0, 40'd29};
        vt[2] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 40'h0040000000};
        vt[3] = '{16'h8000, 16'h8000, 1'b1, 1'b1, 40'hFFC0000000};
        vt[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 40'hFFC0000001};
        vt[5] = '{16'h7FFF, 16'h7FFF, 1'b0, 1'b1, 40'h003FFF0001};
        vt[6] = '{16'h1234, 16'h0000, 1'b0, 1'b0, 40'h003FFF0001};
        vt[7] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 40'h007FFE8001};
        vt[8] = '{16'd5,    16'hFFFD, 1'b0, 1'b1, 40'hFFFFFFFFF1};

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_ready", {63'd0, ready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_acc", {24'd0, acc}, 64'd0);
        chk("rst_step", {61'd0, step}, 64'd0);
        chk("rst_trip", {61'd0, y_trip}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", {63'd0, ready}, 64'd1);

        // directed vector table, accumulating in sequence
        foreach (vt[i]) run_op(vt[i].x, vt[i].y, vt[i].msub, vt[i].clr, vt[i].exp, $sformatf("vec%0d", i));

        // start pulses during RUN must be ignored
        wait_ready();
        x = 16'd3; y = 16'd5; msub = 1'b0; clr = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        dcount = 0;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n >= 2 && n <= 5) begin
                x = 16'd100; y = 16'd100; msub = 1'b1; clr = 1'b1; start = 1'b1;
            end else start = 1'b0;
            if (done) dcount++;
        end
        chk("ignore_done_cnt", 64'(dcount), 64'd1);
        chk("ignore_acc", {24'd0, acc}, 64'd15);

        // reset in the middle of RUN aborts the operation
        wait_ready();
        x = 16'd3; y = 16'd5; msub = 1'b0; clr = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        found = 0;
        for (int n = 0; n < 12 && !found; n++) begin
            @(negedge clk);
            if (busy && step == 3'd4) found = 1;
        end
        chk("abort_reach_step4", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_acc", {24'd0, acc}, 64'd0);
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_ready", {63'd0, ready}, 64'd0);
        chk("abort_step", {61'd0, step}, 64'd0);
        chk("abort_trip", {61'd0, y_trip}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", 64'(dcount), 64'd0);
        chk("abort_acc_hold", {24'd0, acc}, 64'd0);
        run_op(16'hFFFE, 16'd7, 1'b0, 1'b0, 40'hFFFFFFFFF2, "after_abort");

        // pseudo-random operations against an arithmetic reference model
        m = 40'hFFFFFFFFF2;
        for (int i = 0; i < 200; i++) begin
            rx = 16'($urandom);
            ry = 16'($urandom);
            rm = 1'($urandom);
            rc = ($urandom_range(0, 7) == 0);
            p = longint'($signed(rx)) * longint'($signed(ry));
            if (rc) m = '0;
            m = m + 40'(rm ? -p : p);
            run_op(rx, ry, rm, rc, m, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule

// File: doc/mac_booth_seq.md
MAC_BOOTH_SEQ -- requirements
Module: mac_booth_seq

Interface
REQ-001 SHALL have parameter ACC_W, default 40: accumulator width in bits; legal range 34..64.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request a new multiply-accumulate.
REQ-005 SHALL have port x, input, 16 bits: signed two's-complement multiplicand.
REQ-006 SHALL have port y, input, 16 bits: signed two's-complement multiplier, Booth-recoded radix-4.
REQ-007 SHALL have port msub, input, 1 bit: 1 = subtract x*y from acc; 0 = add x*y to acc.
REQ-008 SHALL have port clr, input, 1 bit: 1 = zero acc before the operation accumulates.
REQ-009 SHALL have port ready, output, 1 bit: 1 when a start is accepted this cycle.
REQ-010 SHALL have port busy, output, 1 bit: 1 while Booth steps are in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse; acc is final.
REQ-012 SHALL have port acc, output, ACC_W bits: signed accumulator, registered.
REQ-013 SHALL have port y_trip, output, 3 bits: Booth triplet of the current step; 3'b000 when not busy.
REQ-014 SHALL have port step, output, 3 bits: current Booth step index 0..7; 0 when not busy.

Function
REQ-015 SHALL implement FSM states IDLE, RUN and DONE.
REQ-016 ready SHALL be 1 only in IDLE; busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE.
REQ-017 IDLE with start=1 at a rising edge SHALL: latch x, y and msub; set acc to 0 if clr=1, otherwise hold acc; set step to 0; go to RUN.
REQ-018 start SHALL be ignored in RUN and DONE; operands presented then SHALL have no effect.
REQ-019 For step k, the triplet SHALL be {y[2k+1], y[2k], y[2k-1]}, with y[-1] = 0.
REQ-020 Triplet decode SHALL be: 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
REQ-021 When latched msub=1, the sign of every nonzero partial product SHALL be inverted.
REQ-022 The partial product SHALL be formed in 18 bits signed (2X included), then sign-extended to ACC_W and shifted left by 2k.
REQ-023 In RUN, at each edge, acc SHALL add the partial product and step SHALL increment.
REQ-024 The addition SHALL wrap modulo 2^ACC_W; no saturation and no overflow flag.
REQ-025 In RUN, at the edge where step=7 is accumulated, the FSM SHALL go to DONE.
REQ-026 DONE SHALL last exactly one cycle, then the FSM SHALL return to IDLE.
REQ-027 Timing: acceptance edge E; steps 0..7 accumulate at edges E+1..E+8; done=1 in the cycle after E+8; ready=1 again after edge E+9.
REQ-028 acc SHALL change only at the acceptance edge (clr=1) and at RUN edges; it SHALL hold its value in IDLE and DONE.
REQ-029 After completion, acc SHALL equal acc_prev (or 0 if clr=1) + x*y (msub=0) or - x*y (msub=1), mod 2^ACC_W.
REQ-030 x = 16'h8000 and y = 16'h8000 SHALL be handled exactly (product +2^30), with no special-casing.

Reset
REQ-031 rst_n=0 SHALL asynchronously force: FSM to IDLE, acc=0, step=0, done=0, busy=0, and latched operands to 0.
REQ-032 While rst_n=0, outputs SHALL be ready=0, y_trip=0 and step=0; ready SHALL become 1 from the first cycle after rst_n deasserts.
REQ-033 Reset asserted in RUN or DONE SHALL abort the operation; no done pulse SHALL follow reset release.

Verification
REQ-034 Reset, then x=3, y=5, msub=0, clr=1 -> done 9 cycles after acceptance; acc=15.
REQ-035 Next, x=16'hFFFE, y=7, msub=1, clr=0 -> acc=29; busy high for exactly 8 cycles.
REQ-036 x=16'h8000, y=16'h8000, clr=1, msub=0 -> acc=40'h0040000000. Repeat with msub=1, clr=1 -> acc=40'hFFC0000000.
REQ-037 Pulse start with different operands during RUN -> ignored; result equals the first operation only; exactly one done pulse.
REQ-038 Assert rst_n low at step 4 of RUN -> acc=0 immediately; no done; a fresh start after release completes normally.
REQ-039 Random signed x, y, msub, clr over 10k operations -> acc matches a reference model mod 2^40; y_trip matches REQ-019 every RUN cycle.
